// File: rtl/vga_pkg.sv
// Shared VGA definitions: colour/counter widths, 800x600 active area and the
// default transparent colour key for sprite overlays.
package vga_pkg;

    localparam int RGB_W    = 12;
    localparam int COUNT_W  = 12;
    localparam int H_ACTIVE = 800;
    localparam int V_ACTIVE = 600;

    localparam logic [RGB_W-1:0] KEY_RGB_DEFAULT = 12'hF0F;

    typedef struct packed {
        logic [COUNT_W-1:0] hcount;
        logic [COUNT_W-1:0] vcount;
        logic               hsync;
        logic               vsync;
        logic               hblnk;
        logic               vblnk;
    } vga_timing_t;

    // Half-open span test done one bit wider so lo+size can never wrap.
    function automatic logic in_span(input logic [COUNT_W-1:0] c,
                                     input logic [COUNT_W-1:0] lo,
                                     input logic [COUNT_W:0]   size);
        logic [COUNT_W:0] hi;
        hi = {1'b0, lo} + size;
        return ({1'b0, c} >= {1'b0, lo}) && ({1'b0, c} < hi);
    endfunction

endpackage

// File: rtl/vga_delay.sv
// N-stage register delay line with synchronous active-high reset.
module vga_delay #(
    parameter int W = 1,
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] pipe [N];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= d;
            for (int i = 1; i < N; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign q = pipe[N-1];

endmodule

// File: rtl/draw_sprite.sv
// Overlays a bitmap sprite from an external ROM onto the VGA stream at a
// position latched once per frame; two-stage pipeline, timing delayed to match.
module draw_sprite
    import vga_pkg::*;
#(
    parameter int                 WIDTH   = 64,
    parameter int                 HEIGHT  = 64,
    parameter int                 ADDR_W  = 12,
    parameter logic [RGB_W-1:0]   KEY_RGB = KEY_RGB_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [COUNT_W-1:0] hcount_in,
    input  logic [COUNT_W-1:0] vcount_in,
    input  logic               hsync_in,
    input  logic               vsync_in,
    input  logic               hblnk_in,
    input  logic               vblnk_in,
    input  logic [RGB_W-1:0]   rgb_in,
    input  logic [COUNT_W-1:0] xpos,
    input  logic [COUNT_W-1:0] ypos,
    input  logic [RGB_W-1:0]   rgb_pixel,
    output logic [ADDR_W-1:0]  pixel_addr,
    output logic [COUNT_W-1:0] hcount_out,
    output logic [COUNT_W-1:0] vcount_out,
    output logic               hsync_out,
    output logic               vsync_out,
    output logic               hblnk_out,
    output logic               vblnk_out,
    output logic [RGB_W-1:0]   rgb_out
);

    localparam int XW = $clog2(WIDTH);
    localparam int YW = $clog2(HEIGHT);
    localparam int TW = $bits(vga_timing_t);

    vga_timing_t timing_in;
    vga_timing_t timing_out;

    logic               vblnk_prev;
    logic [COUNT_W-1:0] x_lat;
    logic [COUNT_W-1:0] y_lat;

    logic               in_rect;
    logic [XW-1:0]      col;
    logic [YW-1:0]      row;

    logic               in_rect_s1;
    logic               blank_s1;
    logic [RGB_W-1:0]   rgb_s1;

    // Position only moves on the vblnk rising edge, so a frame never tears.
    always_ff @(posedge clk) begin
        if (rst) begin
            vblnk_prev <= 1'b0;
            x_lat      <= '0;
            y_lat      <= '0;
        end else begin
            vblnk_prev <= vblnk_in;
            if (vblnk_in && !vblnk_prev) begin
                x_lat <= xpos;
                y_lat <= ypos;
            end
        end
    end

    always_comb begin
        in_rect = in_span(hcount_in, x_lat, (COUNT_W+1)'(WIDTH)) &&
                  in_span(vcount_in, y_lat, (COUNT_W+1)'(HEIGHT));
        col     = XW'(hcount_in - x_lat);
        row     = YW'(vcount_in - y_lat);
    end

    // pixel_addr is the ROM's address register; it holds outside the sprite
    // so the ROM sees no needless address toggling.
    always_ff @(posedge clk) begin
        if (rst) begin
            pixel_addr <= '0;
            in_rect_s1 <= 1'b0;
            blank_s1   <= 1'b0;
            rgb_s1     <= '0;
        end else begin
            if (in_rect) pixel_addr <= ADDR_W'({row, col});
            in_rect_s1 <= in_rect;
            blank_s1   <= hblnk_in | vblnk_in;
            rgb_s1     <= rgb_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rgb_out <= '0;
        end else if (blank_s1) begin
            rgb_out <= '0;
        end else if (in_rect_s1 && (rgb_pixel != KEY_RGB)) begin
            rgb_out <= rgb_pixel;
        end else begin
            rgb_out <= rgb_s1;
        end
    end

    assign timing_in = '{hcount: hcount_in, vcount: vcount_in,
                         hsync: hsync_in, vsync: vsync_in,
                         hblnk: hblnk_in, vblnk: vblnk_in};

    vga_delay #(.W(TW), .N(2)) u_timing_dly (
        .clk (clk),
        .rst (rst),
        .d   (timing_in),
        .q   (timing_out)
    );

    assign hcount_out = timing_out.hcount;
    assign vcount_out = timing_out.vcount;
    assign hsync_out  = timing_out.hsync;
    assign vsync_out  = timing_out.vsync;
    assign hblnk_out  = timing_out.hblnk;
    assign vblnk_out  = timing_out.vblnk;

endmodule

// File: tb/tb_draw_sprite.sv
// Self-checking bench for draw_sprite: directed scenarios plus randomized
// pixels against a cycle-level reference model with its own sprite ROM.
module tb_draw_sprite;

    localparam logic [11:0] KEY = 12'hF0F;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] hcount_in, vcount_in, rgb_in, xpos, ypos, rgb_pixel;
    logic        hsync_in, vsync_in, hblnk_in, vblnk_in;
    logic [11:0] pixel_addr, hcount_out, vcount_out, rgb_out;
    logic        hsync_out, vsync_out, hblnk_out, vblnk_out;

    always #5 clk = ~clk;

    draw_sprite dut (
        .clk(clk), .rst(rst),
        .hcount_in(hcount_in), .vcount_in(vcount_in),
        .hsync_in(hsync_in), .vsync_in(vsync_in),
        .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
        .rgb_in(rgb_in), .xpos(xpos), .ypos(ypos),
        .rgb_pixel(rgb_pixel), .pixel_addr(pixel_addr),
        .hcount_out(hcount_out), .vcount_out(vcount_out),
        .hsync_out(hsync_out), .vsync_out(vsync_out),
        .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
        .rgb_out(rgb_out)
    );

    // Sprite ROM: pixel_addr is its address register, data follows it.
    logic [11:0] rom [0:4095];
    assign rgb_pixel = rom[pixel_addr];

    typedef struct packed {
        logic [11:0] h, v;
        logic        hs, vs, hb, vb;
        logic [11:0] rgb;
    } rec_t;

    int          checks = 0;
    int          errors = 0;
    rec_t        s1, exp_o;
    logic [11:0] exp_addr, m_x, m_y;
    logic        m_prev;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // One clock: advance the reference model, clock the DUT, compare.
    task automatic cyc();
        rec_t nr;
        logic inr;
        int   hx, vy, lx, ly;
        if (rst) begin
            exp_o = '0; s1 = '0; exp_addr = '0;
            m_x = '0; m_y = '0; m_prev = 1'b0;
        end else begin
            hx = int'(hcount_in); vy = int'(vcount_in);
            lx = int'(m_x);       ly = int'(m_y);
            inr = (hx >= lx) && (hx < lx + 64) && (vy >= ly) && (vy < ly + 64);
            if (inr) exp_addr = 12'((((vy - ly) % 64) * 64) + ((hx - lx) % 64));
            nr.h = hcount_in; nr.v = vcount_in;
            nr.hs = hsync_in; nr.vs = vsync_in; nr.hb = hblnk_in; nr.vb = vblnk_in;
            if (hblnk_in || vblnk_in)                nr.rgb = 12'h000;
            else if (inr && rom[exp_addr] != KEY)    nr.rgb = rom[exp_addr];
            else                                     nr.rgb = rgb_in;
            exp_o = s1;
            s1    = nr;
            if (vblnk_in && !m_prev) begin m_x = xpos; m_y = ypos; end
            m_prev = vblnk_in;
        end
        @(posedge clk);
        #1;
        chk("pixel_addr", 64'(pixel_addr), 64'(exp_addr));
        chk("rgb_out", 64'(rgb_out), 64'(exp_o.rgb));
        chk("timing", 64'({hcount_out, vcount_out, vsync_out, hblnk_out, vblnk_out}),
            64'({exp_o.h, exp_o.v, exp_o.vs, exp_o.hb, exp_o.vb}));
        chk("hsync_align", 64'(hsync_out), 64'(exp_o.hs));
    endtask

    task automatic drive(input int h, input int v, input logic hb, input logic vb,
                         input logic [11:0] rgb);
        hcount_in = 12'(h);
        vcount_in = 12'(v);
        hblnk_in  = hb;
        vblnk_in  = vb;
        rgb_in    = rgb;
        hsync_in  = 1'($urandom);
        vsync_in  = 1'($urandom);
        cyc();
    endtask

    task automatic pix(input int h, input int v, input logic [11:0] rgb);
        drive(h, v, 1'b0, 1'b0, rgb);
    endtask

    task automatic vb_pulse();
        drive(0, 600, 1'b0, 1'b0, 12'h0);
        drive(0, 600, 1'b0, 1'b1, 12'h0);
        drive(0, 601, 1'b0, 1'b1, 12'h0);
        drive(0, 0,   1'b0, 1'b0, 12'h0);
    endtask

    initial begin
        int h, v;
        for (int i = 0; i < 4096; i++) begin
            rom[i] = 12'($urandom);
            if (rom[i] == KEY) rom[i] = 12'h000;
        end
        for (int i = 0; i < 4096; i += 37) rom[i] = KEY;
        rom[0]      = 12'h0A5;
        rom[12'h083] = KEY;

        rst = 1'b1; xpos = '0; ypos = '0;
        hcount_in = '0; vcount_in = '0; rgb_in = '0;
        hsync_in = 0; vsync_in = 0; hblnk_in = 0; vblnk_in = 0;
        cyc(); cyc();
        chk("reset_rgb", 64'(rgb_out), 64'h0);
        chk("reset_addr", 64'(pixel_addr), 64'h0);
        rst = 1'b0;

        // Sprite at (100,50): corners and just-outside pixels.
        xpos = 100; ypos = 50; vb_pulse();
        pix(100, 50, 12'h777);
        chk("t1_addr_origin", 64'(pixel_addr), 64'h000);
        pix(10, 10, 12'h111);
        chk("t1_rgb_rom0", 64'(rgb_out), 64'h0A5);
        pix(163, 113, 12'h222);
        chk("t2_addr_last", 64'(pixel_addr), 64'hFFF);
        pix(164, 113, 12'h321);
        pix(163, 114, 12'h456);
        chk("t2_right_out", 64'(rgb_out), 64'h321);
        pix(0, 0, 12'h000);
        chk("t2_below_out", 64'(rgb_out), 64'h456);

        // Mid-frame move does not take effect until the next vblnk rise.
        xpos = 300;
        pix(100, 50, 12'h010);
        chk("t3_old_pos", 64'(pixel_addr), 64'h000);
        pix(101, 50, 12'h010);
        chk("t3_old_pos_col1", 64'(pixel_addr), 64'h001);
        vb_pulse();
        pix(302, 51, 12'h020);
        chk("t3_new_pos", 64'(pixel_addr), 64'h042);
        pix(100, 50, 12'h030);
        chk("t3_old_gone", 64'(pixel_addr), 64'h042);

        // Transparent key shows background.
        pix(303, 52, 12'h123);
        chk("t4_key_addr", 64'(pixel_addr), 64'h083);
        pix(0, 0, 12'h000);
        chk("t4_key_rgb", 64'(rgb_out), 64'h123);

        // Right-edge clipping by blanking, no wrap-around hit at low columns.
        xpos = 780; ypos = 0; vb_pulse();
        for (int x = 770; x < 844; x++) drive(x, 5, (x >= 800), 1'b0, 12'($urandom));
        for (int x = 0; x < 44; x++) pix(x, 5, 12'($urandom));
        xpos = 4090; ypos = 4090; vb_pulse();
        for (int x = 0; x < 64; x++) pix(x, x % 8, 12'($urandom));

        // Mid-line reset: outputs clear, sprite returns to (0,0).
        xpos = 200; ypos = 200; vb_pulse();
        for (int x = 190; x < 230; x++) pix(x, 210, 12'($urandom));
        rst = 1'b1;
        pix(215, 210, 12'h5A5);
        chk("t6_rst_rgb", 64'(rgb_out), 64'h0);
        chk("t6_rst_addr", 64'(pixel_addr), 64'h0);
        chk("t6_rst_hcount", 64'(hcount_out), 64'h0);
        rst = 1'b0;
        pix(5, 3, 12'h0F0);
        chk("t6_origin_addr", 64'(pixel_addr), 64'h0C5);
        for (int i = 0; i < 100; i++) pix($urandom_range(0, 80), $urandom_range(0, 80), 12'($urandom));
        xpos = 400; ypos = 300; vb_pulse();
        for (int i = 0; i < 100; i++) pix($urandom_range(380, 480), $urandom_range(290, 380), 12'($urandom));

        // Randomized scan around a randomly placed sprite.
        for (int i = 0; i < 2500; i++) begin
            if (i % 250 == 0) begin
                xpos = 12'($urandom_range(0, 850));
                ypos = 12'($urandom_range(0, 650));
                vb_pulse();
            end
            if ($urandom_range(0, 3) != 0) begin
                h = int'(m_x) + int'($urandom_range(0, 79)) - 8;
                v = int'(m_y) + int'($urandom_range(0, 79)) - 8;
            end else begin
                h = int'($urandom_range(0, 1055));
                v = int'($urandom_range(0, 627));
            end
            drive(h, v, (h >= 800), (v >= 600 && v < 628), 12'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
